// File: rtl/dff_pkg.sv
// ============================================================================
//  Module      : dff_pkg
//  Description : Shared helpers for the dff register / delay-line block.
//                Holds the parameter legality check used at elaboration.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

package dff_pkg;

   localparam int c_MIN_WIDTH = 1;
   localparam int c_MIN_DEPTH = 1;

   // True when the width/depth pair describes a buildable register chain.
   function automatic bit dff_params_ok(input int width, input int depth);
      return (width >= c_MIN_WIDTH) && (depth >= c_MIN_DEPTH);
   endfunction

endpackage : dff_pkg

`default_nettype wire

// File: rtl/dff_stage.sv
// ============================================================================
//  Module      : dff_stage
//  Description : One WIDTH-bit register stage with synchronous, active-low
//                reset to RST_VAL.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active-low (0 = reset)
//                i_d  - stage data input  [WIDTH-1:0]
//                o_q  - stage data output [WIDTH-1:0], straight from flop
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module dff_stage #(
   parameter int                 WIDTH   = 1,
   parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   i_d,
   output logic [WIDTH-1:0]   o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q <= RST_VAL;
      end else begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule : dff_stage

`default_nettype wire

// File: rtl/dff.sv
// ============================================================================
//  Module      : dff
//  Description : Parameterisable D-type register / fixed-latency delay line.
//                DEPTH stages of WIDTH bits each; q is the last stage, so the
//                d-to-q latency is exactly DEPTH rising edges. Every stage is
//                loaded with RST_VAL on an edge that samples rst = 0.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active-low (0 = reset)
//                d    - data input  [WIDTH-1:0]
//                q    - data output [WIDTH-1:0], driven from final stage flop
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module dff
   import dff_pkg::*;
#(
   parameter int                 WIDTH   = 1,
   parameter int                 DEPTH   = 1,
   parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   d,
   output logic [WIDTH-1:0]   q
);

   // Refuse to build a chain with no stages or no bits.
   if (!dff_params_ok(WIDTH, DEPTH)) begin : g_bad_params
      $fatal(1, "dff: WIDTH (%0d) and DEPTH (%0d) must both be >= 1", WIDTH, DEPTH);
   end

   // w_stage[0] is the chain input; w_stage[i+1] is the output of stage i.
   logic [WIDTH-1:0] w_stage [0:DEPTH];

   assign w_stage[0] = d;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      dff_stage #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_stage (
         .clk (clk),
         .rst (rst),
         .i_d (w_stage[gi]),
         .o_q (w_stage[gi+1])
      );
   end

   assign q = w_stage[DEPTH];

endmodule : dff

`default_nettype wire

// File: tb/tb_dff.sv
// ============================================================================
//  Module      : tb_dff
//  Description : Self-checking bench for dff. Two instances share one clock:
//                the default 1-bit/1-stage flop and an 8-bit/3-stage delay
//                line with RST_VAL = 8'hA5. The driver pushes hand-computed
//                expected outputs into a queue; the monitor pops one entry
//                after every rising edge and re-checks it at the falling edge
//                to confirm q holds between edges.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_dff;

   logic       clk;
   logic       rst1;
   logic       d1;
   logic       q1;
   logic       rst8;
   logic [7:0] d8;
   logic [7:0] q8;

   typedef struct {
      logic       exp1;
      logic [7:0] exp8;
   } exp_t;

   exp_t sb_q [$];
   exp_t r_cur;
   bit   r_cur_valid;

   int n_checks;
   int n_pass;

   dff u_dut1 (
      .clk (clk),
      .rst (rst1),
      .d   (d1),
      .q   (q1)
   );

   dff #(
      .WIDTH   (8),
      .DEPTH   (3),
      .RST_VAL (8'hA5)
   ) u_dut8 (
      .clk (clk),
      .rst (rst8),
      .d   (d8),
      .q   (q8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: the entry for the edge just taken is checked 1 time unit later.
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         r_cur       = sb_q.pop_front();
         r_cur_valid = 1'b1;
         chk("q1_after_edge", {7'b0, q1}, {7'b0, r_cur.exp1});
         chk("q8_after_edge", q8, r_cur.exp8);
      end
   end

   // Mid-cycle: q must still hold the value from the previous edge.
   always @(negedge clk) begin
      if (r_cur_valid) begin
         chk("q1_hold", {7'b0, q1}, {7'b0, r_cur.exp1});
         chk("q8_hold", q8, r_cur.exp8);
      end
   end

   // Drive one cycle: set inputs, push expectation for the coming edge,
   // optionally glitch d1 or pulse both resets low strictly between edges.
   task automatic cycle(input logic r1, input logic dd1, input logic e1,
                        input logic r8, input logic [7:0] dd8, input logic [7:0] e8,
                        input bit glitch_d, input bit pulse_rst);
      exp_t e;
      rst1 = r1;
      d1   = dd1;
      rst8 = r8;
      d8   = dd8;
      e.exp1 = e1;
      e.exp8 = e8;
      sb_q.push_back(e);
      if (glitch_d) begin
         #1 d1 = ~dd1; d8 = ~dd8;
         #3 d1 = dd1;  d8 = dd8;
      end else if (pulse_rst) begin
         #1 rst1 = 1'b0; rst8 = 1'b0;
         #3 rst1 = r1;   rst8 = r8;
      end
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      r_cur_valid = 1'b0;
      //     rst1 d1 e1   rst8 d8     e8     glitch pulse
      // Reset held; d toggles underneath it.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hA5, 0, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 0, 0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hA5, 0, 0);
      // Release: first edge captures; 3-stage line shows A5 for two edges.
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'hA5, 0, 0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 8'hA5, 0, 0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 8'h01, 0, 0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 8'h02, 0, 0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 8'h03, 0, 0);
      // Mid-stream reset discards 04/05 in flight.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h06, 8'hA5, 0, 0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h07, 8'hA5, 0, 0);
      // d glitches between edges; only the settled value is captured.
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 8'hA5, 1, 0);
      // Reset pulsed low between edges only; must be ignored.
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h09, 8'h07, 0, 1);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h0A, 8'h08, 0, 0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h0B, 8'h09, 1, 0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h0C, 8'h0A, 0, 1);
      // Let the final falling-edge hold check happen.
      #5;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_dff

`default_nettype wire
